// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Groups the hazard sequencer's pipeline-facing signals into one bundle.
//   master : drives pipeline status (memory handshake, branch, register fields)
//            and observes the freeze/flush/bubble controls.
//   slave  : the hazard controller itself (pipeline_hazard_ctrl).
// Signals:
//   mem_req, mem_ready          MEM-stage SRAM handshake
//   branch_taken                EXE resolved a taken branch
//   id_src1, id_src2            ID source registers
//   id_uses_src1, id_two_src    ID source-read enables
//   exe_wb_en, exe_dest         EXE writeback enable / destination
//   exe_mem_r_en                EXE instruction is a load
//   mem_wb_en, mem_dest         MEM writeback enable / destination
//   freeze_front, freeze_back   freeze PC+IF/ID / freeze ID/EXE..MEM/WB
//   flush, bubble               squash IF/ID+ID/EXE / NOP into ID/EXE
//   mem_timeout                 sticky wait-state timeout error
//   stall_count                 saturating count of front-freeze cycles
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             mem_req;
    logic             mem_ready;
    logic             branch_taken;
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_two_src;
    logic             id_uses_src1;
    logic             exe_wb_en;
    logic [3:0]       exe_dest;
    logic             exe_mem_r_en;
    logic             mem_wb_en;
    logic [3:0]       mem_dest;
    logic             freeze_front;
    logic             freeze_back;
    logic             flush;
    logic             bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output mem_req, mem_ready, branch_taken,
        output id_src1, id_src2, id_two_src, id_uses_src1,
        output exe_wb_en, exe_dest, exe_mem_r_en, mem_wb_en, mem_dest,
        input  freeze_front, freeze_back, flush, bubble, mem_timeout, stall_count
    );

    modport slave (
        input  mem_req, mem_ready, branch_taken,
        input  id_src1, id_src2, id_two_src, id_uses_src1,
        input  exe_wb_en, exe_dest, exe_mem_r_en, mem_wb_en, mem_dest,
        output freeze_front, freeze_back, flush, bubble, mem_timeout, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage ARM pipeline. Combines memory
// wait-states, RAW/load-use hazards and taken-branch squashes into the freeze,
// flush and bubble controls of the pipeline registers. A branch that resolves
// while the pipeline is frozen by memory is remembered and flushed as soon as
// the memory stall ends.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   pipeline_hazard_ctrl_if.slave (see interface file for signal list)
// Parameters:
//   MEM_TIMEOUT  consecutive wait cycles tolerated before mem_timeout (>=2)
//   CNT_W        width of the saturating stall-cycle counter
// Configuration macro:
//   FWD_EN  defined   -> only load-use hazards stall (forwarding covers the rest)
//           undefined -> any RAW against EXE or MEM destinations stalls
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;
    logic              br_pend;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic mem_stall;
    logic exe_match;
    logic mem_match;
    logic hz;
    logic hz_eff;
    logic flush_c;
    logic freeze_front_c;

    // Source-vs-destination comparisons for the ID instruction
    assign exe_match = (bus.id_uses_src1 & (bus.id_src1 == bus.exe_dest)) |
                       (bus.id_two_src   & (bus.id_src2 == bus.exe_dest));
    assign mem_match = (bus.id_uses_src1 & (bus.id_src1 == bus.mem_dest)) |
                       (bus.id_two_src   & (bus.id_src2 == bus.mem_dest));

`ifdef FWD_EN
    // Forwarding resolves everything except a load feeding the next instruction
    logic unused_mem_stage;
    assign unused_mem_stage = ^{bus.mem_wb_en, mem_match};
    assign hz = bus.exe_wb_en & bus.exe_mem_r_en & exe_match;
`else
    logic unused_load_flag;
    assign unused_load_flag = bus.exe_mem_r_en;
    assign hz = (bus.exe_wb_en & exe_match) | (bus.mem_wb_en & mem_match);
`endif

    // Priority: memory stall, then flush, then data hazard. Everything is
    // gated by rst so the pipeline sees quiet controls while in reset.
    assign mem_stall      = rst & bus.mem_req & ~bus.mem_ready;
    assign flush_c        = rst & ~mem_stall & (bus.branch_taken | br_pend);
    assign hz_eff         = rst & ~mem_stall & ~flush_c & hz;
    assign freeze_front_c = mem_stall | hz_eff;

    assign bus.freeze_front = freeze_front_c;
    assign bus.freeze_back  = mem_stall;
    assign bus.flush        = flush_c;
    assign bus.bubble       = hz_eff;
    assign bus.mem_timeout  = timeout_q;
    assign bus.stall_count  = stall_cnt_q;

    // Wait-state FSM: tracks how long the SRAM has kept us waiting and raises
    // the sticky timeout flag; the stall itself is never cut short.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    wait_cnt <= '0;
                    if (mem_stall) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_ready) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else begin
                        if (wait_cnt == WAIT_LAST) begin
                            timeout_q <= 1'b1;
                        end
                        if (wait_cnt != WAIT_MAX) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Deferred branch flush: frozen registers would ignore a flush, so a
    // branch seen during a memory stall is held until the stall clears.
    always_ff @(posedge clk) begin
        if (!rst) begin
            br_pend <= 1'b0;
        end else if (mem_stall && bus.branch_taken) begin
            br_pend <= 1'b1;
        end else if (flush_c) begin
            br_pend <= 1'b0;
        end
    end

    // Saturating count of cycles in which the front end was frozen
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (freeze_front_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4 and CNT_W=4 so
// that timeout and counter saturation are reachable in a few cycles.
// Expectations follow FWD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   check_cnt;
    int   pass_cnt;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    // Compare one observed value against its expectation
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drive every pipeline input in one call
    task automatic applyStimulus(input logic req, input logic rdy, input logic br,
                                 input logic [3:0] s1, input logic u1,
                                 input logic [3:0] s2, input logic two,
                                 input logic ewb, input logic [3:0] ed, input logic eld,
                                 input logic mwb, input logic [3:0] md);
        bus.mem_req      = req;
        bus.mem_ready    = rdy;
        bus.branch_taken = br;
        bus.id_src1      = s1;
        bus.id_uses_src1 = u1;
        bus.id_src2      = s2;
        bus.id_two_src   = two;
        bus.exe_wb_en    = ewb;
        bus.exe_dest     = ed;
        bus.exe_mem_r_en = eld;
        bus.mem_wb_en    = mwb;
        bus.mem_dest     = md;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0);
    endtask

    task automatic memStim(input logic req, input logic rdy, input logic br);
        applyStimulus(req, rdy, br, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0);
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkControls(input string tag, input logic ff, input logic fb,
                                 input logic fl, input logic bb);
        checkOutput({tag, ".freeze_front"}, 32'(bus.freeze_front), 32'(ff));
        checkOutput({tag, ".freeze_back"},  32'(bus.freeze_back),  32'(fb));
        checkOutput({tag, ".flush"},        32'(bus.flush),        32'(fl));
        checkOutput({tag, ".bubble"},       32'(bus.bubble),       32'(bb));
    endtask

    task automatic doReset();
        rst = 1'b0;
        idle();
        step();
        step();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        rst       = 1'b0;
        idle();

        // Reset: controls stay quiet in reset even with active requests
        step();
        memStim(1, 0, 1);
        checkControls("rst_gate", 0, 0, 0, 0);
        doReset();
        checkControls("reset", 0, 0, 0, 0);
        checkOutput("reset.mem_timeout", 32'(bus.mem_timeout), 0);
        checkOutput("reset.stall_count", 32'(bus.stall_count), 0);

        // Three-cycle memory wait then ready
        for (int i = 0; i < 3; i++) begin
            memStim(1, 0, 0);
            checkControls($sformatf("memwait%0d", i), 1, 1, 0, 0);
            step();
        end
        memStim(1, 1, 0);
        checkControls("memready", 0, 0, 0, 0);
        step();
        idle();
        checkOutput("memwait.stall_count", 32'(bus.stall_count), 3);
        checkOutput("memwait.mem_timeout", 32'(bus.mem_timeout), 0);

        // Plain taken branch flushes immediately
        applyStimulus(0, 0, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0);
        checkControls("branch", 0, 0, 1, 0);
        step();
        idle();
        checkControls("branch_after", 0, 0, 0, 0);

        // Branch during stall is deferred and flushed exactly once
        doReset();
        memStim(1, 0, 0);
        step();
        memStim(1, 0, 1);
        checkControls("defer_c2", 1, 1, 0, 0);
        step();
        memStim(1, 0, 1);
        checkControls("defer_c3", 1, 1, 0, 0);
        step();
        memStim(1, 1, 0);
        checkControls("defer_ready", 0, 0, 1, 0);
        step();
        idle();
        checkControls("defer_after", 0, 0, 0, 0);

        // Data hazards
        doReset();
        applyStimulus(0, 0, 0, 4'd3, 1, 4'd0, 0, 1, 4'd3, 1, 0, 4'd0);
        checkControls("hz_load", 1, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 4'd3, 1, 4'd0, 0, 1, 4'd3, 0, 0, 4'd0);
        checkControls("hz_alu_exe", !FWD, 0, 0, !FWD);
        step();
        applyStimulus(0, 0, 0, 4'd0, 0, 4'd5, 1, 0, 4'd0, 0, 1, 4'd5);
        checkControls("hz_mem", !FWD, 0, 0, !FWD);
        step();
        applyStimulus(0, 0, 0, 4'd3, 0, 4'd3, 0, 1, 4'd3, 1, 1, 4'd3);
        checkControls("hz_unused_src", 0, 0, 0, 0);
        step();
        idle();
        checkOutput("hz.stall_count", 32'(bus.stall_count), FWD ? 32'd1 : 32'd3);

        // Flush beats hazard; memory stall beats both
        applyStimulus(0, 0, 1, 4'd3, 1, 4'd0, 0, 1, 4'd3, 1, 0, 4'd0);
        checkControls("flush_over_hz", 0, 0, 1, 0);
        step();
        applyStimulus(1, 0, 0, 4'd3, 1, 4'd0, 0, 1, 4'd3, 1, 0, 4'd0);
        checkControls("stall_over_hz", 1, 1, 0, 0);
        step();

        // Timeout after the fourth wait cycle, sticky until reset
        doReset();
        for (int i = 1; i <= 6; i++) begin
            memStim(1, 0, 0);
            step();
            checkOutput($sformatf("timeout_e%0d", i), 32'(bus.mem_timeout),
                        (i >= 5) ? 32'd1 : 32'd0);
        end
        memStim(1, 1, 0);
        step();
        idle();
        step();
        checkOutput("timeout_sticky", 32'(bus.mem_timeout), 1);
        checkOutput("timeout.stall_count", 32'(bus.stall_count), 6);

        // Counter saturates at all-ones
        for (int i = 0; i < 12; i++) begin
            memStim(1, 0, 0);
            step();
        end
        idle();
        checkOutput("stall_count_sat", 32'(bus.stall_count), 15);

        // Reset mid-wait drops a pending branch flush and clears status
        memStim(1, 0, 1);
        step();
        doReset();
        checkControls("rst_drops_pend", 0, 0, 0, 0);
        checkOutput("rst.mem_timeout", 32'(bus.mem_timeout), 0);
        checkOutput("rst.stall_count", 32'(bus.stall_count), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
